song_rater: RTL and testbench

Scores one learn-mode play session and produces the two 4-bit grades consumed by the per-user account store. Each expected-note window is compared with the key the player held. At song end, a sequential divider turns the hit count and the longest streak into 0..10 grades. The grades are held stable for the evaluate phase that follows.

---
 rtl/song_rater_pkg.sv | 23 ++
 rtl/rater_divider.sv | 66 ++++++
 rtl/song_rater.sv | 160 ++++++++++++++++
 tb/tb_song_rater.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_rater_pkg.sv
// Shared constants for the learn-mode song rater: global mode encodings,
// note encoding, grading scale and the rater's FSM states.
package song_rater_pkg;

    localparam logic [1:0] MODE_IDLE     = 2'd0;
    localparam logic [1:0] MODE_LEARN    = 2'd1;
    localparam logic [1:0] MODE_EVALUATE = 2'd2;
    localparam logic [1:0] MODE_FREE     = 2'd3;

    localparam logic [2:0] NOTE_NONE = 3'd0;

    localparam int GRADE_MAX = 10;
    localparam int GRADE_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CALC1,
        S_CALC2,
        S_DONE
    } rater_state_e;

endpackage

// File: rtl/rater_divider.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle.
// done and quotient reflect the final iteration during the cycle it completes.
module rater_divider
    import song_rater_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W+3:0]     dividend,
    input  logic [CNT_W-1:0]     divisor,
    output logic [GRADE_W-1:0]   quotient,
    output logic                 done,
    output logic                 busy
);

    localparam int NUM_W  = CNT_W + 4;
    localparam int STEP_W = $clog2(NUM_W + 1);

    logic [CNT_W-1:0]  rem;
    logic [NUM_W-1:0]  quo;
    logic [CNT_W-1:0]  dvs;
    logic [STEP_W-1:0] steps;
    logic              running;

    logic [CNT_W:0]    trial;
    logic              fits;
    logic [CNT_W-1:0]  rem_next;
    logic [NUM_W-1:0]  quo_next;

    // Low bits of the subtraction are exact because the result is below dvs.
    always_comb begin
        trial    = {rem, quo[NUM_W-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? (trial[CNT_W-1:0] - dvs) : trial[CNT_W-1:0];
        quo_next = {quo[NUM_W-2:0], fits};
        done     = running && (steps == STEP_W'(1));
        quotient = quo_next[GRADE_W-1:0];
        busy     = running;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            steps   <= '0;
            running <= 1'b0;
        end else if (running) begin
            rem   <= rem_next;
            quo   <= quo_next;
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
                running <= 1'b0;
            end
        end else if (start) begin
            rem     <= '0;
            quo     <= dividend;
            dvs     <= divisor;
            steps   <= STEP_W'(NUM_W);
            running <= 1'b1;
        end
    end

endmodule

// File: rtl/song_rater.sv
// Scores one learn-mode play session: counts hits and the best streak while
// playing, then grades both against the judged-note total with a shared divider.
module song_rater #(
    parameter int CNT_W     = 8,
    parameter int GRADE_MAX = song_rater_pkg::GRADE_MAX
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         state,
    input  logic                               start,
    input  logic                               note_strobe,
    input  logic [2:0]                         expected_note,
    input  logic [2:0]                         played_note,
    input  logic                               song_end,
    output logic [song_rater_pkg::GRADE_W-1:0] rating1,
    output logic [song_rater_pkg::GRADE_W-1:0] rating2,
    output logic                               rating_valid,
    output logic                               busy,
    output logic [CNT_W-1:0]                   hit_count,
    output logic [CNT_W-1:0]                   total_count
);

    import song_rater_pkg::*;

    localparam int               NUM_W   = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rater_state_e fsm, fsm_next;

    logic [CNT_W-1:0]   streak;
    logic [CNT_W-1:0]   best;
    logic [GRADE_W-1:0] grade1;

    logic               active;
    logic               judge;
    logic               is_match;
    logic               clear_counts;
    logic [CNT_W-1:0]   total_next;
    logic [CNT_W-1:0]   streak_inc;

    logic               div_start;
    logic               div_done;
    logic               div_busy;
    logic [NUM_W-1:0]   div_dividend;
    logic [GRADE_W-1:0] div_quotient;

    // A restart takes priority over a strobe arriving in the same cycle;
    // total_next lets song_end see a note counted in its own cycle.
    always_comb begin
        active       = (state == MODE_LEARN);
        clear_counts = active && start && ((fsm == S_IDLE) || (fsm == S_PLAY));
        judge        = (fsm == S_PLAY) && active && !start && note_strobe
                       && (expected_note != NOTE_NONE) && (total_count != CNT_MAX);
        is_match     = (played_note == expected_note);
        total_next   = judge ? total_count + CNT_W'(1) : total_count;
        streak_inc   = streak + CNT_W'(1);
        div_dividend = (fsm == S_CALC2) ? NUM_W'(best) * NUM_W'(GRADE_MAX)
                                        : NUM_W'(hit_count) * NUM_W'(GRADE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            S_IDLE: begin
                if (active && start) fsm_next = S_PLAY;
            end
            S_PLAY: begin
                if (!active)        fsm_next = S_IDLE;
                else if (start)     fsm_next = S_PLAY;
                else if (song_end)  fsm_next = (total_next != '0) ? S_CALC1 : S_DONE;
            end
            S_CALC1: begin
                if (div_done) fsm_next = S_CALC2;
            end
            S_CALC2: begin
                if (div_done) fsm_next = S_DONE;
            end
            S_DONE:  fsm_next = S_IDLE;
            default: fsm_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        rating_valid = 1'b0;
        div_start    = 1'b0;
        case (fsm)
            S_PLAY: busy = 1'b1;
            S_CALC1, S_CALC2: begin
                busy      = 1'b1;
                div_start = !div_busy;
            end
            S_DONE:  rating_valid = 1'b1;
            default: ;
        endcase
    end

    // Ratings change only on the edge entering DONE, so they hold across aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count   <= '0;
            total_count <= '0;
            streak      <= '0;
            best        <= '0;
            grade1      <= '0;
            rating1     <= '0;
            rating2     <= '0;
        end else begin
            if (clear_counts) begin
                hit_count   <= '0;
                total_count <= '0;
                streak      <= '0;
                best        <= '0;
            end else if (judge) begin
                total_count <= total_next;
                if (is_match) begin
                    hit_count <= hit_count + CNT_W'(1);
                    streak    <= streak_inc;
                    if (streak_inc > best) best <= streak_inc;
                end else begin
                    streak <= '0;
                end
            end

            if ((fsm == S_CALC1) && div_done) begin
                grade1 <= div_quotient;
            end

            if ((fsm == S_PLAY) && (fsm_next == S_DONE)) begin
                rating1 <= '0;
                rating2 <= '0;
            end else if ((fsm == S_CALC2) && div_done) begin
                rating1 <= grade1;
                rating2 <= div_quotient;
            end
        end
    end

    rater_divider #(
        .CNT_W(CNT_W)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (total_count),
        .quotient(div_quotient),
        .done    (div_done),
        .busy    (div_busy)
    );

endmodule

// File: tb/tb_song_rater.sv
// Self-checking bench for song_rater: table-driven sessions, hand-written
// corner sequences and randomized sessions scored by a session-level model.
module tb_song_rater;

    import song_rater_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       start;
    logic       note_strobe;
    logic [2:0] expected_note;
    logic [2:0] played_note;
    logic       song_end;
    logic [3:0] rating1;
    logic [3:0] rating2;
    logic       rating_valid;
    logic       busy;
    logic [7:0] hit_count;
    logic [7:0] total_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          n_notes;
        int          n_rests;
        logic [31:0] hit_mask;
        int          exp_total;
        int          exp_hit;
        int          exp_r1;
        int          exp_r2;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [2:0] e;
        logic [2:0] p;
    } note_t;

    vec_t  vecs[7];
    note_t notes_q[$];

    song_rater dut (
        .clk          (clk),
        .reset        (reset),
        .state        (mode),
        .start        (start),
        .note_strobe  (note_strobe),
        .expected_note(expected_note),
        .played_note  (played_note),
        .song_end     (song_end),
        .rating1      (rating1),
        .rating2      (rating2),
        .rating_valid (rating_valid),
        .busy         (busy),
        .hit_count    (hit_count),
        .total_count  (total_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        note_strobe = 1'b0;
        song_end    = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        notes_q.delete();
        cycle();
    endtask

    task automatic strobe(input logic [2:0] e, input logic [2:0] p);
        note_strobe   = 1'b1;
        expected_note = e;
        played_note   = p;
        notes_q.push_back('{e, p});
        cycle();
    endtask

    // Session-level reference: walk the judged notes in order.
    task automatic score(output int total, output int hit, output int best);
        int streak = 0;
        total = 0;
        hit   = 0;
        best  = 0;
        foreach (notes_q[i]) begin
            if (notes_q[i].e != 3'd0 && total < 255) begin
                total++;
                if (notes_q[i].p == notes_q[i].e) begin
                    hit++;
                    streak++;
                    if (streak > best) best = streak;
                end else begin
                    streak = 0;
                end
            end
        end
    endtask

    task automatic finishAndCheck(input bit with_note, input logic [2:0] e, input logic [2:0] p,
                                  input int exp_total, input int exp_hit, input int exp_r1,
                                  input int exp_r2, input int exp_lat, input string tag);
        int lat  = 0;
        bit seen = 1'b0;
        song_end = 1'b1;
        if (with_note) begin
            note_strobe   = 1'b1;
            expected_note = e;
            played_note   = p;
            notes_q.push_back('{e, p});
        end
        while (!seen && lat < 64) begin
            cycle();
            lat++;
            if (rating_valid) seen = 1'b1;
        end
        checkOutput({tag, ".valid_seen"}, int'(seen), 1);
        checkOutput({tag, ".latency"}, lat, exp_lat);
        checkOutput({tag, ".rating1"}, int'(rating1), exp_r1);
        checkOutput({tag, ".rating2"}, int'(rating2), exp_r2);
        checkOutput({tag, ".total"}, int'(total_count), exp_total);
        checkOutput({tag, ".hit"}, int'(hit_count), exp_hit);
        checkOutput({tag, ".busy_at_valid"}, int'(busy), 0);
        cycle();
        checkOutput({tag, ".valid_pulse"}, int'(rating_valid), 0);
        checkOutput({tag, ".rating1_hold"}, int'(rating1), exp_r1);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        logic [2:0] e;
        logic [2:0] p;
        pulseStart();
        for (int r = 0; r < v.n_rests; r++) strobe(NOTE_NONE, 3'(r + 1));
        for (int i = 0; i < v.n_notes; i++) begin
            e = 3'((i % 7) + 1);
            p = v.hit_mask[i] ? e : 3'(((i % 7) + 1) % 7 + 1);
            strobe(e, p);
        end
        finishAndCheck(1'b0, 3'd0, 3'd0, v.exp_total, v.exp_hit, v.exp_r1, v.exp_r2,
                       v.exp_lat, tag);
    endtask

    task automatic watchNoValid(input int cycles, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            cycle();
            if (rating_valid) seen = 1'b1;
        end
        checkOutput({tag, ".no_valid"}, int'(seen), 0);
    endtask

    initial begin
        int t, h, b, n, lat_exp;
        bit with_note;
        logic [2:0] e, p;

        vecs[0] = '{10, 0, 32'h0F7, 10, 7, 7, 4, 27};
        vecs[1] = '{3,  2, 32'h003, 3,  2, 6, 6, 27};
        vecs[2] = '{0,  0, 32'h000, 0,  0, 0, 0, 1};
        vecs[3] = '{7,  0, 32'h000, 7,  0, 0, 0, 27};
        vecs[4] = '{6,  0, 32'h02D, 6,  4, 6, 3, 27};
        vecs[5] = '{1,  0, 32'h001, 1,  1, 10, 10, 27};
        vecs[6] = '{9,  0, 32'h101, 9,  2, 2, 1, 27};

        reset = 1'b1; mode = MODE_LEARN; start = 1'b0; note_strobe = 1'b0;
        expected_note = 3'd0; played_note = 3'd0; song_end = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset.rating1", int'(rating1), 0);
        checkOutput("reset.rating2", int'(rating2), 0);
        checkOutput("reset.valid", int'(rating_valid), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.hit", int'(hit_count), 0);
        checkOutput("reset.total", int'(total_count), 0);

        for (int k = 0; k < 7; k++) applyStimulus(vecs[k], $sformatf("vec%0d", k));

        // Restart inside PLAY clears counters and keeps playing.
        pulseStart();
        checkOutput("restart.busy", int'(busy), 1);
        repeat (3) strobe(3'd1, 3'd2);
        checkOutput("restart.total_before", int'(total_count), 3);
        pulseStart();
        checkOutput("restart.total_cleared", int'(total_count), 0);
        checkOutput("restart.busy_after", int'(busy), 1);
        strobe(3'd4, 3'd4);
        checkOutput("restart.hit_next_cycle", int'(hit_count), 1);
        strobe(3'd5, 3'd5);
        finishAndCheck(1'b0, 3'd0, 3'd0, 2, 2, 10, 10, 27, "restart");

        // Abort leaves the previous ratings untouched.
        applyStimulus(vecs[0], "abort_pre");
        pulseStart();
        repeat (5) strobe(3'd2, 3'd2);
        mode = MODE_EVALUATE;
        cycle();
        checkOutput("abort.busy", int'(busy), 0);
        checkOutput("abort.hit", int'(hit_count), 5);
        watchNoValid(30, "abort");
        checkOutput("abort.rating1", int'(rating1), 7);
        checkOutput("abort.rating2", int'(rating2), 4);
        start = 1'b1;
        cycle();
        checkOutput("abort.start_outside_learn", int'(busy), 0);
        mode = MODE_LEARN;
        cycle();

        // Saturation at 255, final strobe coincident with song_end.
        pulseStart();
        repeat (299) strobe(3'd3, 3'd3);
        finishAndCheck(1'b1, 3'd3, 3'd3, 255, 255, 10, 10, 27, "saturate");

        // Reset while the divider is running.
        pulseStart();
        strobe(3'd1, 3'd1); strobe(3'd2, 3'd3); strobe(3'd6, 3'd6); strobe(3'd7, 3'd7);
        song_end = 1'b1;
        cycle();
        repeat (4) cycle();
        checkOutput("middiv.busy_before", int'(busy), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checkOutput("middiv.rating1", int'(rating1), 0);
        checkOutput("middiv.rating2", int'(rating2), 0);
        checkOutput("middiv.valid", int'(rating_valid), 0);
        checkOutput("middiv.busy", int'(busy), 0);
        checkOutput("middiv.hit", int'(hit_count), 0);
        checkOutput("middiv.total", int'(total_count), 0);
        watchNoValid(30, "middiv");
        applyStimulus(vecs[4], "middiv_after");

        // Randomized sessions against the session-level model.
        for (int s = 0; s < 12; s++) begin
            pulseStart();
            n = int'($urandom_range(0, 30));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) cycle();
                e = 3'($urandom_range(0, 7));
                p = ($urandom_range(0, 9) < 6) ? e : 3'($urandom_range(0, 7));
                strobe(e, p);
            end
            with_note = 1'($urandom_range(0, 1));
            e = 3'($urandom_range(1, 7));
            p = ($urandom_range(0, 1) == 1) ? e : 3'($urandom_range(0, 7));
            if (with_note) notes_q.push_back('{e, p});
            score(t, h, b);
            if (with_note) void'(notes_q.pop_back());
            lat_exp = (t > 0) ? 27 : 1;
            finishAndCheck(with_note, e, p, t, h, (t > 0) ? (h * 10) / t : 0,
                           (t > 0) ? (b * 10) / t : 0, lat_exp, $sformatf("rand%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
